// File: rtl/pointwise_op_engine_if.sv
// rtl/pointwise_op_engine_if.sv - start/done handshake and A/B/C/output memory bus of the pointwise engine
// Optional abort/aborted signals are present only when POINTWISE_OP_ABORT_EN is defined.
interface pointwise_op_engine_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 128
);
  logic              start;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic [DATA_W-1:0] c_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
`ifdef POINTWISE_OP_ABORT_EN
  logic              abort;
  logic              aborted;

  modport master (
    output start, mode, a_data, b_data, c_data, abort,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, aborted
  );

  modport slave (
    input  start, mode, a_data, b_data, c_data, abort,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, aborted
  );
`else
  modport master (
    output start, mode, a_data, b_data, c_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, mode, a_data, b_data, c_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
`endif
endinterface

// File: rtl/pointwise_op_engine.sv
// rtl/pointwise_op_engine.sv - LANES-wide pointwise MUL/ADD/SUB/MAC mod Q engine (optional abort: POINTWISE_OP_ABORT_EN)
// Pipeline from rd_en to wr_en is MUL_LATENCY+2 cycles in every mode; MUL_LATENCY must be at least 2
// (one product stage, one reduction stage, the rest is delay).
module pointwise_op_engine #(
  parameter int N           = 1024,
  parameter int K           = 32,
  parameter int Q           = 12289,
  parameter int LANES       = 4,
  parameter int MUL_LATENCY = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pointwise_op_engine_if.slave   bus
);
  localparam int BATCHES = N / LANES;
  localparam int ADDR_W  = $clog2(BATCHES);
  localparam int CNT_W   = ADDR_W + 1;
  localparam int DATA_W  = LANES * K;
  localparam int ML      = MUL_LATENCY;

  localparam logic [CNT_W-1:0] CNT_BATCHES = CNT_W'(BATCHES);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BATCHES - 1);
  localparam logic [K:0]       Q_SUM       = (K+1)'(Q);
  localparam logic [K-1:0]     Q_K         = K'(Q);
  localparam logic [2*K-1:0]   Q_PROD      = (2*K)'(Q);

  localparam logic [1:0] MODE_MUL = 2'd0;
  localparam logic [1:0] MODE_ADD = 2'd1;
  localparam logic [1:0] MODE_SUB = 2'd2;
  localparam logic [1:0] MODE_MAC = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_PROC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic              abort_hit;
  logic              rd_fire;
  logic              wr_fire;

  // Read-side valid/address, then one valid/address per multiplier stage, then the output register.
  logic              rd_vld_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ML-1:0]     vld_pipe;
  logic [ADDR_W-1:0] addr_pipe [ML];
  logic              wr_vld_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  // Data pipeline: operands ride alongside the product so ADD/SUB/MAC see them aligned.
  logic [K-1:0]      a_pipe   [ML][LANES];
  logic [K-1:0]      b_pipe   [ML][LANES];
  logic [K-1:0]      c_pipe   [ML][LANES];
  logic [2*K-1:0]    prod_q   [LANES];
  logic [K-1:0]      red_pipe [ML-1][LANES];
  logic [DATA_W-1:0] result_word;

`ifdef POINTWISE_OP_ABORT_EN
  logic              aborted_q;
  assign abort_hit   = bus.abort && (state_q == S_PROC);
  assign bus.aborted = aborted_q;
`else
  assign abort_hit   = 1'b0;
`endif

  assign rd_fire     = (state_q == S_PROC) && (rd_cnt_q < CNT_BATCHES) && !abort_hit;
  assign wr_fire     = wr_vld_q && !abort_hit;

  assign bus.rd_en   = rd_fire;
  assign bus.rd_addr = rd_cnt_q[ADDR_W-1:0];
  assign bus.wr_en   = wr_fire;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = (state_q == S_PROC);
  assign bus.done    = (state_q == S_DONE);

  function automatic logic [K-1:0] mod_add(input logic [K-1:0] x, input logic [K-1:0] y);
    logic [K:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= Q_SUM) ? K'(s - Q_SUM) : K'(s);
  endfunction

  function automatic logic [K-1:0] mod_sub(input logic [K-1:0] x, input logic [K-1:0] y);
    return (x >= y) ? (x - y) : (x - y + Q_K);
  endfunction

  // State register, latched mode and read/write counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_MUL;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.start) begin
        mode_q <= bus.mode;
      end
      if (state_q != S_PROC || abort_hit) begin
        rd_cnt_q <= '0;
        wr_cnt_q <= '0;
      end else begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(rd_fire);
        wr_cnt_q <= wr_cnt_q + CNT_W'(wr_fire);
      end
    end
  end

  // Next state: leave PROCESSING on the cycle the final write is issued so DONE follows it directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_PROC;
      S_PROC: begin
        if (abort_hit) begin
          state_d = S_IDLE;
        end else if (wr_fire && wr_cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef POINTWISE_OP_ABORT_EN
  // One-cycle acknowledgement of an accepted abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
    end
  end
`endif

  // Valid/address chain; an abort flushes every in-flight word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      vld_pipe  <= '0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      for (int s = 0; s < ML; s++) addr_pipe[s] <= '0;
    end else if (abort_hit) begin
      rd_vld_q <= 1'b0;
      vld_pipe <= '0;
      wr_vld_q <= 1'b0;
    end else begin
      rd_vld_q     <= rd_fire;
      rd_addr_q    <= bus.rd_addr;
      vld_pipe     <= {vld_pipe[ML-2:0], rd_vld_q};
      addr_pipe[0] <= rd_addr_q;
      for (int s = 1; s < ML; s++) addr_pipe[s] <= addr_pipe[s-1];
      wr_vld_q     <= vld_pipe[ML-1];
      wr_addr_q    <= addr_pipe[ML-1];
    end
  end

  // Multiplier: product in stage 0, reduction into stage 1, plain delay afterwards.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      a_pipe[0][l] <= bus.a_data[l*K +: K];
      b_pipe[0][l] <= bus.b_data[l*K +: K];
      c_pipe[0][l] <= bus.c_data[l*K +: K];
      prod_q[l]    <= (2*K)'(bus.a_data[l*K +: K]) * (2*K)'(bus.b_data[l*K +: K]);
      red_pipe[0][l] <= K'(prod_q[l] % Q_PROD);
      for (int s = 1; s < ML; s++) begin
        a_pipe[s][l] <= a_pipe[s-1][l];
        b_pipe[s][l] <= b_pipe[s-1][l];
        c_pipe[s][l] <= c_pipe[s-1][l];
      end
      for (int s = 1; s < ML - 1; s++) begin
        red_pipe[s][l] <= red_pipe[s-1][l];
      end
    end
  end

  // Per-lane mode select on the aligned operands at the end of the multiplier delay.
  always_comb begin
    result_word = '0;
    for (int l = 0; l < LANES; l++) begin
      case (mode_q)
        MODE_MUL: result_word[l*K +: K] = red_pipe[ML-2][l];
        MODE_ADD: result_word[l*K +: K] = mod_add(a_pipe[ML-1][l], b_pipe[ML-1][l]);
        MODE_SUB: result_word[l*K +: K] = mod_sub(a_pipe[ML-1][l], b_pipe[ML-1][l]);
        default:  result_word[l*K +: K] = mod_add(red_pipe[ML-2][l], c_pipe[ML-1][l]);
      endcase
    end
  end

  // Registered output word; zero between writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_data_q <= '0;
    end else begin
      wr_data_q <= vld_pipe[ML-1] ? result_word : '0;
    end
  end
endmodule

// File: tb/tb_pointwise_op_engine.sv
// tb/tb_pointwise_op_engine.sv - self-checking bench for pointwise_op_engine (abort steps under POINTWISE_OP_ABORT_EN)
module tb_pointwise_op_engine;
  localparam int N       = 16;
  localparam int K       = 32;
  localparam int Q       = 12289;
  localparam int LANES   = 4;
  localparam int ML      = 10;
  localparam int BATCHES = N / LANES;
  localparam int ADDR_W  = 2;
  localparam int DW      = LANES * K;
  localparam int PIPE    = ML + 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pointwise_op_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DW)) bus ();

  pointwise_op_engine #(
    .N(N), .K(K), .Q(Q), .LANES(LANES), .MUL_LATENCY(ML)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int unsigned mem_a [N];
  int unsigned mem_b [N];
  int unsigned mem_c [N];
  int unsigned outv  [N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count, first_wr, last_wr, done_cyc, done_cnt, addr_err, busy_at_done, aborted_cnt;

  // Synchronous-read memory model for the A/B/C banks.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      for (int l = 0; l < LANES; l++) begin
        bus.a_data[l*K +: K] <= mem_a[int'(bus.rd_addr)*LANES + l];
        bus.b_data[l*K +: K] <= mem_b[int'(bus.rd_addr)*LANES + l];
        bus.c_data[l*K +: K] <= mem_c[int'(bus.rd_addr)*LANES + l];
      end
    end
  end

  // Output monitor: records writes, done and abort activity with the cycle number.
  always @(posedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (wr_count == 0) first_wr = cyc;
      last_wr = cyc;
      if (wr_count >= BATCHES || int'(bus.wr_addr) != wr_count) addr_err++;
      for (int l = 0; l < LANES; l++) outv[int'(bus.wr_addr)*LANES + l] = bus.wr_data[l*K +: K];
      wr_count++;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = int'(bus.busy);
    end
`ifdef POINTWISE_OP_ABORT_EN
    if (bus.aborted === 1'b1) aborted_cnt++;
`endif
    cyc++;
  end

  function automatic int unsigned ref_op(int m, int unsigned a, int unsigned b, int unsigned c);
    longint la = a, lb = b, lc = c;
    case (m)
      0: return int'((la * lb) % Q);
      1: return int'((la + lb) % Q);
      2: return int'((la - lb + Q) % Q);
      default: return int'(((la * lb) % Q + lc) % Q);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_capture();
    wr_count = 0; first_wr = -1; last_wr = -1; done_cyc = -1; done_cnt = 0;
    addr_err = 0; busy_at_done = -1; aborted_cnt = 0;
    for (int j = 0; j < N; j++) outv[j] = 32'hFFFF_FFFF;
  endtask

  task automatic start_run(input int m, output int t0);
    @(negedge clk);
    bus.mode  = 2'(m);
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt > 0), 64'(1));
  endtask

  task automatic check_run(input string tag, input int t0, input int m);
    check({tag, "_wr_count"}, 64'(wr_count), 64'(BATCHES));
    check({tag, "_first_wr"}, 64'(first_wr), 64'(t0 + 1 + PIPE));
    check({tag, "_last_wr"},  64'(last_wr),  64'(t0 + BATCHES + PIPE));
    check({tag, "_done_cyc"}, 64'(done_cyc), 64'(t0 + BATCHES + PIPE + 1));
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
    check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'(0));
    check({tag, "_wr_addr_order"}, 64'(addr_err), 64'(0));
    for (int j = 0; j < N; j++)
      check($sformatf("%s_out%0d", tag, j), 64'(outv[j]), 64'(ref_op(m, mem_a[j], mem_b[j], mem_c[j])));
  endtask

  task automatic full_run(input string tag, input int m);
    int t0;
    clear_capture();
    start_run(m, t0);
    wait_done(tag);
    check_run(tag, t0, m);
  endtask

  task automatic fill_random();
    for (int j = 0; j < N; j++) begin
      mem_a[j] = $urandom_range(Q - 1, 0);
      mem_b[j] = $urandom_range(Q - 1, 0);
      mem_c[j] = $urandom_range(Q - 1, 0);
    end
    mem_a[0] = Q - 1; mem_b[0] = Q - 1; mem_c[0] = Q - 1;
    mem_a[1] = 0;     mem_b[1] = Q - 1; mem_c[1] = 0;
  endtask

  initial begin
    int t0, d, seen, snap, n;
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.mode = 2'd0;
    bus.a_data = '0;
    bus.b_data = '0;
    bus.c_data = '0;
`ifdef POINTWISE_OP_ABORT_EN
    bus.abort = 1'b0;
`endif
    clear_capture();
    repeat (3) @(negedge clk);
    check("rst_busy",    64'(bus.busy),    64'(0));
    check("rst_done",    64'(bus.done),    64'(0));
    check("rst_rd_en",   64'(bus.rd_en),   64'(0));
    check("rst_rd_addr", 64'(bus.rd_addr), 64'(0));
    check("rst_wr_en",   64'(bus.wr_en),   64'(0));
    check("rst_wr_addr", 64'(bus.wr_addr), 64'(0));
    check("rst_wr_data", 64'((bus.wr_data === '0) ? 0 : 1), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    for (int j = 0; j < N; j++) begin mem_a[j] = j + 1; mem_b[j] = 2; mem_c[j] = 0; end
    full_run("mul_dir", 0);
    check("mul_dir_out0_const",  64'(outv[0]),  64'(2));
    check("mul_dir_out15_const", 64'(outv[15]), 64'(32));

    for (int j = 0; j < N; j++) begin mem_a[j] = 12288; mem_b[j] = j; end
    full_run("add_wrap", 1);
    check("add_wrap_out0_const", 64'(outv[0]), 64'(12288));
    check("add_wrap_out1_const", 64'(outv[1]), 64'(0));

    for (int j = 0; j < N; j++) begin mem_a[j] = 0; mem_b[j] = j; end
    full_run("sub_wrap", 2);
    check("sub_wrap_out1_const", 64'(outv[1]), 64'(12288));

    for (int j = 0; j < N; j++) begin mem_a[j] = 3; mem_b[j] = 4; mem_c[j] = 12280; end
    full_run("mac_dir", 3);
    check("mac_dir_out5_const", 64'(outv[5]), 64'(3));

    for (int m = 0; m < 4; m++) begin
      for (int r = 0; r < 2; r++) begin
        fill_random();
        full_run($sformatf("rand_m%0d_r%0d", m, r), m);
      end
    end

    // start held high across a run with a mid-run mode change
    fill_random();
    clear_capture();
    @(negedge clk);
    bus.mode = 2'd1;
    bus.start = 1'b1;
    t0 = cyc;
    repeat (3) @(negedge clk);
    bus.mode = 2'd2;
    wait_done("held1");
    check_run("held1", t0, 1);
    d = done_cyc;
    clear_capture();
    @(negedge clk);
    bus.start = 1'b0;
    check("held2_busy", 64'(bus.busy), 64'(1));
    wait_done("held2");
    check_run("held2", d + 1, 2);

    // reset pulsed during the second write cycle
    fill_random();
    clear_capture();
    start_run(0, t0);
    seen = 0;
    n = 0;
    while (seen < 2 && n < 100) begin
      @(negedge clk);
      if (bus.wr_en === 1'b1) seen++;
      n++;
    end
    check("rst_mid_reached_wr2", 64'(seen), 64'(2));
    reset_n = 1'b0;
    #1;
    check("rst_mid_wr_en",   64'(bus.wr_en), 64'(0));
    check("rst_mid_busy",    64'(bus.busy),  64'(0));
    check("rst_mid_rd_en",   64'(bus.rd_en), 64'(0));
    check("rst_mid_wr_data", 64'((bus.wr_data === '0) ? 0 : 1), 64'(0));
    snap = wr_count;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_mid_no_more_wr", 64'(wr_count), 64'(snap));
    check("rst_mid_no_done",    64'(done_cnt), 64'(0));
    full_run("after_rst", 3);

`ifdef POINTWISE_OP_ABORT_EN
    fill_random();
    clear_capture();
    start_run(0, t0);
    while (cyc < t0 + 5) @(negedge clk);
    bus.abort = 1'b1;
    #1;
    check("abort_rd_en", 64'(bus.rd_en), 64'(0));
    check("abort_wr_en", 64'(bus.wr_en), 64'(0));
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_pulse_cyc", 64'(cyc), 64'(t0 + 6));
    check("abort_aborted",   64'(bus.aborted), 64'(1));
    check("abort_busy",      64'(bus.busy), 64'(0));
    repeat (20) @(negedge clk);
    check("abort_no_writes",   64'(wr_count), 64'(0));
    check("abort_no_done",     64'(done_cnt), 64'(0));
    check("abort_aborted_cnt", 64'(aborted_cnt), 64'(1));
    full_run("after_abort", 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
